// File: rtl/conv_pkg.sv
// Shared constants for the Conv3x3 engine datapath.
package conv_pkg;

  localparam int unsigned FP_W        = 32;
  localparam int unsigned MUL_LAT     = 2;
  localparam int unsigned SIGN_BIT    = 31;
  localparam int unsigned EXP_MSB     = 30;
  localparam int unsigned EXP_LSB     = 23;
  localparam int unsigned MAN_MSB     = 22;
  localparam int unsigned NUM_REQ_DEF = 4;

endpackage

// File: rtl/Mul.sv
// Combinational FP32 multiplier: sign XOR, biased exponent sum, 24x24
// mantissa product, single-bit normalise, truncation. No special values.
module Mul
  import conv_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] y
);

  localparam int unsigned MW = MAN_MSB + 2;          // mantissa with hidden bit
  localparam int unsigned EW = EXP_MSB - EXP_LSB + 1;

  logic [MW-1:0]   ma;
  logic [MW-1:0]   mb;
  logic [2*MW-1:0] prod;
  logic            norm;
  logic [MAN_MSB:0] frac;
  logic [EW-1:0]   e_sum;
  logic            unused_prod_lo;

  // Product, normalise by one bit when the mantissa product reaches 2.0
  always_comb begin
    ma    = {1'b1, a[MAN_MSB:0]};
    mb    = {1'b1, b[MAN_MSB:0]};
    prod  = {{MW{1'b0}}, ma} * {{MW{1'b0}}, mb};
    norm  = prod[2*MW-1];
    frac  = norm ? prod[2*MW-2 -: MAN_MSB+1] : prod[2*MW-3 -: MAN_MSB+1];
    e_sum = a[EXP_MSB:EXP_LSB] + b[EXP_MSB:EXP_LSB] - EW'(127) + {{(EW-1){1'b0}}, norm};
    y     = {a[SIGN_BIT] ^ b[SIGN_BIT], e_sum, frac};
  end

  assign unused_prod_lo = ^prod[MAN_MSB:0];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; search begins one past 'last'.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int unsigned idx;
  logic        found;

  // First requesting index after 'last', wrapping modulo N
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = (32'(last) + off) % N;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one FP32 multiplier between NUM_REQ requesters,
// with registered operands (S1) and registered product (S2).
module fp_mul_arbiter
  import conv_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      res_valid,
  output logic [FP_W-1:0]         res_data,
  input  logic [NUM_REQ-1:0]      res_ready,
  output logic                    busy
);

  logic [FP_W-1:0]  a1_q, a1_d, b1_q, b1_d, p2_q, p2_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, last_q, last_d;
  logic             v1_q, v1_d, v2_q, v2_d;

  logic [FP_W-1:0]    a_arr [NUM_REQ];
  logic [FP_W-1:0]    b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt;
  logic [TAG_W-1:0]   gnt_idx;
  logic [FP_W-1:0]    mul_y;
  logic               s1_adv, s2_adv, arb_en, fire;

  // Split packed operand buses into per-requester words
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*FP_W +: FP_W];
      b_arr[i] = req_b[i*FP_W +: FP_W];
    end
  end

  // Pipeline advance conditions; only the result owner's ready matters
  always_comb begin
    s2_adv = !v2_q || res_ready[tag2_q];
    s1_adv = !v1_q || s2_adv;
    // rst_n gating keeps req_ready low for the whole reset window
    arb_en = s1_adv && rst_n;
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .last    (last_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  Mul u_mul (
    .a (a1_q),
    .b (b1_q),
    .y (mul_y)
  );

  assign req_ready = gnt;
  assign fire      = |gnt;

  // Next-state for both stages and the round-robin pointer
  always_comb begin
    a1_d   = a1_q;
    b1_d   = b1_q;
    tag1_d = tag1_q;
    v1_d   = v1_q;
    p2_d   = p2_q;
    tag2_d = tag2_q;
    v2_d   = v2_q;
    last_d = last_q;
    if (s2_adv) begin
      v2_d = v1_q;
      if (v1_q) begin
        p2_d   = mul_y;
        tag2_d = tag1_q;
      end
    end
    if (s1_adv) begin
      v1_d = fire;
      if (fire) begin
        a1_d   = a_arr[gnt_idx];
        b1_d   = b_arr[gnt_idx];
        tag1_d = gnt_idx;
        last_d = gnt_idx;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q   <= '0;
      b1_q   <= '0;
      tag1_q <= '0;
      v1_q   <= 1'b0;
      p2_q   <= '0;
      tag2_q <= '0;
      v2_q   <= 1'b0;
      last_q <= TAG_W'(NUM_REQ - 1);
    end else begin
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      tag1_q <= tag1_d;
      v1_q   <= v1_d;
      p2_q   <= p2_d;
      tag2_q <= tag2_d;
      v2_q   <= v2_d;
      last_q <= last_d;
    end
  end

  // One-hot result routing to the owner of the S2 product
  always_comb begin
    res_valid = '0;
    if (v2_q) res_valid[tag2_q] = 1'b1;
  end

  assign res_data = p2_q;
  assign busy     = v1_q | v2_q;

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Shares one combinational FP32 multiplier (`Mul`) among `NUM_REQ` requesters in the Conv3x3 engine. Arbitration is round-robin. Operands and results are registered around the multiplier, giving a 2-stage pipeline. Each result returns only to the requester that issued the operation, with full backpressure. The block sits between the per-window-tap operand fetchers and the accumulation adders.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TAG_W`, `$clog2(NUM_REQ)`: owner-tag width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  requester i has operands ready.
- `req_a`  in  NUM_REQ*32  operand A of requester i, in bits [32i+31:32i].
- `req_b`  in  NUM_REQ*32  operand B of requester i, packed the same way as `req_a`.
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `res_valid`  out  NUM_REQ  one-hot; the result in `res_data` belongs to requester i.
- `res_data`  out  32  registered product.
- `res_ready`  in  NUM_REQ  requester i accepts its result.
- `busy`  out  1  any pipeline stage is occupied.

## Operation
- Stage S1 holds `a1`, `b1`, `tag1` and `v1`. Stage S2 holds `p2`, `tag2` and `v2`. `Mul` sits combinationally between S1 and S2.
- S2 advances when `!v2 | res_ready[tag2]`. S1 advances when `!v1 | s2_adv`. A grant is issued only when S1 advances.
- Round-robin pointer `last`:
  - The search starts at `(last+1) mod NUM_REQ`. The first requester with `req_valid` set wins.
  - `last` updates to the winner only on a completed handshake.
- `req_ready` is combinational from `req_valid`, `last` and the stall state. At most one bit is set.
- `req_ready` must not depend on `res_data`. It never asserts while the pipeline is stalled.
- A requester that deasserts `req_valid` before being granted loses nothing. No grant is issued to it.
- `res_valid = v2 ? (1 << tag2) : 0`. `res_data` and `tag2` stay stable while the result is held unaccepted.
- `res_ready` bits for non-owners are ignored.
- Arithmetic is entirely inside `Mul`: sign XOR, biased exponent sum, 24x24 mantissa product, 1-bit normalise. No rounding, denormal, inf or NaN handling is added here. The product is passed through bit-exact.
- Simultaneous S2 drain and S1 fill in one cycle is legal and required, so back-to-back throughput is 1 op/cycle.
- `busy = v1 | v2`.

## Timing
- Reset (asynchronous, `rst_n` low):
  - `v1`, `v2` cleared; `a1`, `b1`, `p2`, `tag1`, `tag2` set to 0.
  - `last` set to `NUM_REQ-1`, so requester 0 has first priority.
  - Outputs: `req_ready` = 0, `res_valid` = 0, `res_data` = 0, `busy` = 0.
- Reset asserted mid-operation drops in-flight ops silently. Requesters must reissue.
- Latency: a handshake in cycle N puts `res_valid` high in cycle N+2 when there is no backpressure.
- Stall: if `res_ready[tag2]` is low in cycle M, both stages hold and `req_ready` is 0 in cycle M.
- With S1 full and S2 stalled, at most 2 ops are in flight. No ops are lost or reordered.
- Results leave in grant order. A result is never delivered to a requester other than the one granted.

## Structure
- Shared package `conv_pkg`:
  - `FP_W = 32`;
  - `MUL_LAT = 2`;
  - field positions `SIGN_BIT = 31`, `EXP_MSB = 30`, `EXP_LSB = 23`, `MAN_MSB = 22`;
  - default `NUM_REQ`.
- Sub-module `rr_arbiter` (parameter `N`): inputs `req`, `last`, `en`; outputs one-hot `gnt` and encoded `gnt_idx`. It is purely combinational. The `last` register stays in the parent.
- The existing `Mul` is instantiated once, unmodified.

## Test plan
- Single op: requester 0 sends `0x3F800000` × `0x40000000` (1.0 × 2.0). Expect `res_valid=0001` and `res_data=0x40000000` exactly 2 cycles after the handshake.
- Normalise path: requester 2 sends `0x3FC00000` × `0x3FC00000`, giving `0x40100000`. Requester 1 sends `0xC0000000` × `0x40400000`, giving `0xC0C00000` with the sign set.
- Fairness: all 4 requesters hold `req_valid` continuously for 12 cycles. Grants must cycle 0,1,2,3,0,... Each requester gets 3 grants, with 1 result per cycle after fill.
- Backpressure: hold `res_ready[owner]` low for 5 cycles. Expect `res_data` stable, `req_ready` all 0 after S1 fills, and `busy` = 1. On release, both results drain in order on consecutive cycles.
- Misrouted ready: assert `res_ready` for a non-owner only. The result must stay held and must not be dropped.
- Reset mid-flight: assert `rst_n` low with `v1` and `v2` set. All outputs go to 0 immediately. After release, the first grant goes to requester 0.
